rv_ctrl_fsm: RTL and testbench
==============================

Name: rv_ctrl_fsm

Overview:
- Multi-cycle sequencer for the RV32 NPC datapath: fetch, decode, execute, memory, writeback.
- Handshakes with the instruction fetch port and the load/store port.
- Generates the instruction-register, PC and register-file write strobes, replacing the IDU's constant regfile write enable.
- Detects ebreak and illegal opcodes, parks the core in a sticky halt, and keeps a retired-instruction counter.

Parameters:
- WIDTH, 32, datapath and instret counter width.
- TIMEOUT, 1024, cycles allowed for ifu_ready or lsu_ready before a fault. Used only with RV_CTRL_TIMEOUT_EN.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- inst  in  32  instruction word from the fetch port; sampled only on a fetch handshake.
- ifu_req  out  1  fetch request.
- ifu_ready  in  1  fetch data valid.
- inst_we  out  1  one-cycle pulse that latches inst into the IDU instruction register.
- lsu_req  out  1  data memory request.
- lsu_wen  out  1  1 = store, 0 = load; valid while lsu_req is high.
- lsu_ready  in  1  data access complete.
- rf_we  out  1  register-file write enable.
- pc_we  out  1  PC update strobe.
- halt  out  1  sticky: core stopped.
- illegal  out  1  sticky: halt caused by an unsupported opcode.
- timeout  out  1  sticky: halt caused by a handshake timeout.
- state  out  3  current state, for debug.
- instret  out  WIDTH  retired-instruction count.

Behaviour:
- Reset: rst sampled high at a clock edge forces state=FETCH. The same applies mid-operation from any state.
  - All outputs are 0 and instret=0 after that edge.
  - Outstanding requests are dropped without waiting for ready.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 go to HALT with illegal=1.
- FETCH:
  - ifu_req=1, held until ifu_ready is seen.
  - On ifu_ready=1: inst_we=1 in that same cycle, inst[6:0], inst[11:7] and inst[31:20] are captured internally, next state = DECODE.
  - ifu_ready is ignored whenever ifu_req=0.
- DECODE (1 cycle), classifying the captured opcode:
  - SYSTEM (1110011) with inst[31:20]=0x001 (ebreak) -> HALT, illegal=0.
  - Any other SYSTEM word, or an opcode outside {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011} -> HALT with illegal=1.
  - Otherwise -> EXEC.
- EXEC (1 cycle):
  - LOAD (0000011) or STORE (0100011) -> MEM.
  - BRANCH (1100011): pc_we=1, next state FETCH.
  - All other opcodes -> WB.
- MEM:
  - lsu_req=1 held; lsu_wen=1 for STORE.
  - On lsu_ready: LOAD -> WB; STORE -> pc_we=1, next state FETCH.
- WB (1 cycle):
  - rf_we=1 unless captured rd=0.
  - pc_we=1, next state FETCH.
- HALT: halt=1; all request and strobe outputs are 0. Left only by rst.
- instret increments by 1 in every cycle where pc_we=1 and wraps modulo 2^WIDTH.
- Strobes: inst_we, pc_we and rf_we are single-cycle pulses and are never asserted together with rst.
- Latency in cycles, counting from the fetch handshake cycle with zero-wait memory:
  - ALU/jump: 4.
  - Branch: 3.
  - Load: 5.
  - Store: 4.

Optional Feature:
- Macro: RV_CTRL_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to FETCH or MEM and increments each cycle ready is low.
  - When it reaches TIMEOUT, the block drops the request and goes to HALT with timeout=1.
  - If ready arrives in the same cycle the count reaches TIMEOUT, ready wins.
- When not defined:
  - The block waits indefinitely in FETCH and MEM.
  - timeout is tied to 0 and no counter logic is built.

Test Plan:
- Reset then addi x1,x0,5 (0x00500093), ifu_ready tied to 1 -> inst_we at cycle 0, rf_we=1 and pc_we=1 at cycle 3; instret 0 -> 1; state sequence 0,1,2,4,0.
- lw x2,0(x1) (0x0000A103) with lsu_ready delayed 3 cycles -> lsu_req=1 and lsu_wen=0 held for 4 cycles, then a WB pulse with rf_we=1.
- sw (0x0020A023) then beq (0x00000063) -> neither asserts rf_we; store pc_we at cycle 3, branch pc_we at cycle 2; instret ends at 2.
- addi x0,x0,0 (0x00000013) -> WB asserts pc_we=1 with rf_we=0.
- ebreak (0x00100073) -> state=5, halt=1, illegal=0 and stays there for 100 cycles. Opcode 0x0000007F -> halt=1, illegal=1.
- rst asserted in MEM with lsu_req high -> next cycle state=0, lsu_req=0, instret=0. With RV_CTRL_TIMEOUT_EN, TIMEOUT=8 and ifu_ready=0 -> halt=1 and timeout=1 after 8 FETCH cycles.

Source files
------------

// File: rtl/rv_ctrl_if.sv
// rv_ctrl_if: fetch and load/store handshake bundle between rv_ctrl_fsm and the memory ports.
interface rv_ctrl_if;
   logic [31:0] inst;
   logic        ifu_req;
   logic        ifu_ready;
   logic        inst_we;
   logic        lsu_req;
   logic        lsu_wen;
   logic        lsu_ready;
   modport master (input inst, ifu_ready, lsu_ready, output ifu_req, inst_we, lsu_req, lsu_wen);
   modport slave  (output inst, ifu_ready, lsu_ready, input ifu_req, inst_we, lsu_req, lsu_wen);
endinterface

// File: rtl/rv_ctrl_fsm.sv
// rv_ctrl_fsm: multi-cycle fetch/decode/exec/mem/wb sequencer for the RV32 NPC with sticky halt and instret.
// Optional handshake timeout enabled by defining RV_CTRL_TIMEOUT_EN.
module rv_ctrl_fsm #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   rv_ctrl_if.master        bus,
   output logic             rf_we,
   output logic             pc_we,
   output logic             halt,
   output logic             illegal,
   output logic             timeout,
   output logic [2:0]       state,
   output logic [WIDTH-1:0] instret
);
   typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5} state_t;
   state_t           r_state;
   logic [6:0]       r_op;
   logic [4:0]       r_rd;
   logic [11:0]      r_f12;
   logic             r_ifu_req, r_lsu_req, r_lsu_wen, r_halt, r_illegal;
   logic [WIDTH-1:0] r_instret;
   logic             w_fetch_hs, w_mem_hs, w_load, w_store, w_branch, w_legal, w_ebreak, w_expire;
   assign w_fetch_hs = (r_state == FETCH) & r_ifu_req & bus.ifu_ready;
   assign w_mem_hs   = (r_state == MEM) & r_lsu_req & bus.lsu_ready;
   assign w_load     = r_op == 7'b0000011;
   assign w_store    = r_op == 7'b0100011;
   assign w_branch   = r_op == 7'b1100011;
   assign w_ebreak   = (r_op == 7'b1110011) & (r_f12 == 12'h001);
   assign w_legal    = r_op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                    7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
`ifdef RV_CTRL_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] r_cnt;
   logic          r_timeout, w_wait;
   // Counter sits at zero outside a pending handshake, so it is clear on every entry to FETCH/MEM.
   assign w_wait   = ((r_state == FETCH) & ~w_fetch_hs) | ((r_state == MEM) & ~w_mem_hs);
   assign w_expire = w_wait & (r_cnt == CW'(TIMEOUT - 1));
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_cnt     <= w_wait ? r_cnt + 1'b1 : '0;
         r_timeout <= r_timeout | w_expire;
      end
   end
   assign timeout = r_timeout;
`else
   assign w_expire = 1'b0;
   assign timeout  = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= FETCH;
         r_ifu_req <= 1'b0;
         r_lsu_req <= 1'b0;
         r_lsu_wen <= 1'b0;
         r_halt    <= 1'b0;
         r_illegal <= 1'b0;
         r_instret <= '0;
         r_op      <= '0;
         r_rd      <= '0;
         r_f12     <= '0;
      end else begin
         if (pc_we) r_instret <= r_instret + 1'b1;
         case (r_state)
            FETCH: begin
               if (w_fetch_hs) begin
                  r_state   <= DECODE;
                  r_ifu_req <= 1'b0;
                  r_op      <= bus.inst[6:0];
                  r_rd      <= bus.inst[11:7];
                  r_f12     <= bus.inst[31:20];
               end else if (w_expire) begin
                  r_state   <= HALT;
                  r_ifu_req <= 1'b0;
                  r_halt    <= 1'b1;
               end else r_ifu_req <= 1'b1;
            end
            DECODE: begin
               if (w_ebreak | ~w_legal) begin
                  r_state   <= HALT;
                  r_halt    <= 1'b1;
                  r_illegal <= ~w_ebreak;
               end else r_state <= EXEC;
            end
            EXEC: begin
               if (w_load | w_store) begin
                  r_state   <= MEM;
                  r_lsu_req <= 1'b1;
                  r_lsu_wen <= w_store;
               end else if (w_branch) begin
                  r_state   <= FETCH;
                  r_ifu_req <= 1'b1;
               end else r_state <= WB;
            end
            MEM: begin
               if (w_mem_hs) begin
                  r_state   <= r_lsu_wen ? FETCH : WB;
                  r_ifu_req <= r_lsu_wen;
                  r_lsu_req <= 1'b0;
                  r_lsu_wen <= 1'b0;
               end else if (w_expire) begin
                  r_state   <= HALT;
                  r_halt    <= 1'b1;
                  r_lsu_req <= 1'b0;
                  r_lsu_wen <= 1'b0;
               end
            end
            WB: begin
               r_state   <= FETCH;
               r_ifu_req <= 1'b1;
            end
            HALT: ;
            default: begin
               r_state   <= HALT;
               r_halt    <= 1'b1;
               r_illegal <= 1'b1;
            end
         endcase
      end
   end
   // Strobes follow the handshakes combinationally so they land in the handshake cycle itself.
   assign bus.ifu_req = r_ifu_req;
   assign bus.inst_we = w_fetch_hs & ~rst;
   assign bus.lsu_req = r_lsu_req;
   assign bus.lsu_wen = r_lsu_wen;
   assign pc_we       = ~rst & ((r_state == WB) | ((r_state == EXEC) & w_branch) | (w_mem_hs & r_lsu_wen));
   assign rf_we       = ~rst & (r_state == WB) & (r_rd != 5'd0);
   assign halt        = r_halt;
   assign illegal     = r_illegal;
   assign state       = r_state;
   assign instret     = r_instret;
endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// tb_rv_ctrl_fsm: directed-vector bench for rv_ctrl_fsm; covers the timeout path when RV_CTRL_TIMEOUT_EN is defined.
module tb_rv_ctrl_fsm;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rf_we, pc_we, halt, illegal, timeout;
   logic [2:0]  state;
   logic [31:0] instret;
   logic [11:0] obs;
   int          n_cmp = 0;
   int          n_bad = 0;
   rv_ctrl_if bus ();
   rv_ctrl_fsm #(.WIDTH(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .bus(bus), .rf_we(rf_we), .pc_we(pc_we), .halt(halt),
      .illegal(illegal), .timeout(timeout), .state(state), .instret(instret)
   );
   always #5 clk = ~clk;
   // {state, ifu_req, inst_we, lsu_req, lsu_wen, rf_we, pc_we, halt, illegal, timeout}
   assign obs = {state, bus.ifu_req, bus.inst_we, bus.lsu_req, bus.lsu_wen, rf_we, pc_we, halt, illegal, timeout};
   localparam logic [11:0] F_IDLE = {3'd0, 9'b000000000};
   localparam logic [11:0] F_REQ  = {3'd0, 9'b100000000};
   localparam logic [11:0] F_HS   = {3'd0, 9'b110000000};
   localparam logic [11:0] DEC    = {3'd1, 9'b000000000};
   localparam logic [11:0] EXE    = {3'd2, 9'b000000000};
   localparam logic [11:0] EXE_BR = {3'd2, 9'b000001000};
   localparam logic [11:0] MEM_LD = {3'd3, 9'b001000000};
   localparam logic [11:0] MEM_SD = {3'd3, 9'b001101000};
   localparam logic [11:0] MEM_SR = {3'd3, 9'b001100000};
   localparam logic [11:0] WB_RF  = {3'd4, 9'b000011000};
   localparam logic [11:0] WB_X0  = {3'd4, 9'b000001000};
   localparam logic [11:0] H_EB   = {3'd5, 9'b000000100};
   localparam logic [11:0] H_ILL  = {3'd5, 9'b000000110};
   localparam logic [11:0] H_TO   = {3'd5, 9'b000000101};
   // An ebreak on the bus outside handshakes would halt the core if it were wrongly latched.
   localparam logic [31:0] JUNK = 32'h0010_0073;
   typedef struct {logic r; logic ifr; logic lsr; logic [31:0] ins; logic [11:0] exp;} vec_t;
   task automatic cyc(input logic r, input logic ifr, input logic lsr, input logic [31:0] ins);
      @(posedge clk);
      #1;
      rst = r;
      bus.ifu_ready = ifr;
      bus.lsu_ready = lsr;
      bus.inst = ins;
      @(negedge clk);
   endtask
   task automatic do_reset;
      cyc(1'b1, 1'b0, 1'b0, JUNK);
      cyc(1'b0, 1'b0, 1'b0, JUNK);
   endtask
   task automatic test_reset;
      vec_t v [5];
      v = '{'{1'b0, 1'b1, 1'b0, JUNK, F_IDLE}, '{1'b0, 1'b0, 1'b0, JUNK, F_REQ},
            '{1'b1, 1'b1, 1'b0, 32'h0050_0093, F_REQ}, '{1'b0, 1'b0, 1'b0, JUNK, F_IDLE},
            '{1'b0, 1'b0, 1'b0, JUNK, F_REQ}};
      cyc(1'b1, 1'b0, 1'b0, JUNK);
      cyc(1'b1, 1'b0, 1'b0, JUNK);
      foreach (v[i]) begin
         cyc(v[i].r, v[i].ifr, v[i].lsr, v[i].ins);
         n_cmp++;
         if (obs !== v[i].exp) begin n_bad++; $display("FAIL reset[%0d]: obs=%h exp=%h", i, obs, v[i].exp); end
      end
      n_cmp++;
      if (instret !== 32'd0) begin n_bad++; $display("FAIL reset_instret: got %0d want 0", instret); end
   endtask
   task automatic test_alu;
      vec_t v [5];
      v = '{'{1'b0, 1'b1, 1'b0, 32'h0050_0093, F_HS}, '{1'b0, 1'b0, 1'b0, JUNK, DEC},
            '{1'b0, 1'b0, 1'b0, JUNK, EXE}, '{1'b0, 1'b0, 1'b0, JUNK, WB_RF}, '{1'b0, 1'b0, 1'b0, JUNK, F_REQ}};
      foreach (v[i]) begin
         cyc(v[i].r, v[i].ifr, v[i].lsr, v[i].ins);
         n_cmp++;
         if (obs !== v[i].exp) begin n_bad++; $display("FAIL alu[%0d]: obs=%h exp=%h", i, obs, v[i].exp); end
      end
      n_cmp++;
      if (instret !== 32'd1) begin n_bad++; $display("FAIL alu_instret: got %0d want 1", instret); end
   endtask
   task automatic test_load;
      vec_t v [9];
      v = '{'{1'b0, 1'b1, 1'b0, 32'h0000_A103, F_HS}, '{1'b0, 1'b0, 1'b0, JUNK, DEC},
            '{1'b0, 1'b0, 1'b0, JUNK, EXE}, '{1'b0, 1'b0, 1'b0, JUNK, MEM_LD}, '{1'b0, 1'b0, 1'b0, JUNK, MEM_LD},
            '{1'b0, 1'b0, 1'b0, JUNK, MEM_LD}, '{1'b0, 1'b0, 1'b1, JUNK, MEM_LD}, '{1'b0, 1'b0, 1'b0, JUNK, WB_RF},
            '{1'b0, 1'b0, 1'b0, JUNK, F_REQ}};
      foreach (v[i]) begin
         cyc(v[i].r, v[i].ifr, v[i].lsr, v[i].ins);
         n_cmp++;
         if (obs !== v[i].exp) begin n_bad++; $display("FAIL load[%0d]: obs=%h exp=%h", i, obs, v[i].exp); end
      end
      n_cmp++;
      if (instret !== 32'd2) begin n_bad++; $display("FAIL load_instret: got %0d want 2", instret); end
   endtask
   task automatic test_rd_zero;
      vec_t v [5];
      v = '{'{1'b0, 1'b1, 1'b0, 32'h0000_0013, F_HS}, '{1'b0, 1'b0, 1'b0, JUNK, DEC},
            '{1'b0, 1'b0, 1'b0, JUNK, EXE}, '{1'b0, 1'b0, 1'b0, JUNK, WB_X0}, '{1'b0, 1'b0, 1'b0, JUNK, F_REQ}};
      foreach (v[i]) begin
         cyc(v[i].r, v[i].ifr, v[i].lsr, v[i].ins);
         n_cmp++;
         if (obs !== v[i].exp) begin n_bad++; $display("FAIL rd_zero[%0d]: obs=%h exp=%h", i, obs, v[i].exp); end
      end
      n_cmp++;
      if (instret !== 32'd3) begin n_bad++; $display("FAIL rd_zero_instret: got %0d want 3", instret); end
   endtask
   task automatic test_rst_mem;
      vec_t v [6];
      v = '{'{1'b0, 1'b1, 1'b0, 32'h0020_A023, F_HS}, '{1'b0, 1'b0, 1'b0, JUNK, DEC},
            '{1'b0, 1'b0, 1'b0, JUNK, EXE}, '{1'b1, 1'b0, 1'b1, JUNK, MEM_SR}, '{1'b0, 1'b0, 1'b1, JUNK, F_IDLE},
            '{1'b0, 1'b0, 1'b0, JUNK, F_REQ}};
      foreach (v[i]) begin
         cyc(v[i].r, v[i].ifr, v[i].lsr, v[i].ins);
         n_cmp++;
         if (obs !== v[i].exp) begin n_bad++; $display("FAIL rst_mem[%0d]: obs=%h exp=%h", i, obs, v[i].exp); end
      end
      n_cmp++;
      if (instret !== 32'd0) begin n_bad++; $display("FAIL rst_mem_instret: got %0d want 0", instret); end
   endtask
   task automatic test_back_to_back;
      vec_t v [8];
      v = '{'{1'b0, 1'b1, 1'b0, 32'h0020_A023, F_HS}, '{1'b0, 1'b0, 1'b0, JUNK, DEC},
            '{1'b0, 1'b0, 1'b0, JUNK, EXE}, '{1'b0, 1'b0, 1'b1, JUNK, MEM_SD},
            '{1'b0, 1'b1, 1'b0, 32'h0000_0063, F_HS}, '{1'b0, 1'b0, 1'b0, JUNK, DEC},
            '{1'b0, 1'b0, 1'b0, JUNK, EXE_BR}, '{1'b0, 1'b0, 1'b0, JUNK, F_REQ}};
      foreach (v[i]) begin
         cyc(v[i].r, v[i].ifr, v[i].lsr, v[i].ins);
         n_cmp++;
         if (obs !== v[i].exp) begin n_bad++; $display("FAIL back_to_back[%0d]: obs=%h exp=%h", i, obs, v[i].exp); end
      end
      n_cmp++;
      if (instret !== 32'd2) begin n_bad++; $display("FAIL back_to_back_instret: got %0d want 2", instret); end
   endtask
   task automatic test_ebreak;
      vec_t v [3];
      int   bad = 0;
      v = '{'{1'b0, 1'b1, 1'b0, 32'h0010_0073, F_HS}, '{1'b0, 1'b0, 1'b0, 32'h0050_0093, DEC},
            '{1'b0, 1'b1, 1'b1, 32'h0050_0093, H_EB}};
      foreach (v[i]) begin
         cyc(v[i].r, v[i].ifr, v[i].lsr, v[i].ins);
         n_cmp++;
         if (obs !== v[i].exp) begin n_bad++; $display("FAIL ebreak[%0d]: obs=%h exp=%h", i, obs, v[i].exp); end
      end
      for (int k = 0; k < 100; k++) begin
         cyc(1'b0, 1'b1, 1'b1, 32'h0050_0093);
         n_cmp++;
         if (obs !== H_EB) begin
            n_bad++;
            if (bad++ < 3) $display("FAIL ebreak_hold[%0d]: obs=%h exp=%h", k, obs, H_EB);
         end
      end
   endtask
   task automatic test_illegal;
      vec_t v [8];
      v = '{'{1'b0, 1'b1, 1'b0, 32'h0000_007F, F_HS}, '{1'b0, 1'b0, 1'b0, JUNK, DEC},
            '{1'b0, 1'b1, 1'b1, JUNK, H_ILL}, '{1'b1, 1'b1, 1'b1, JUNK, H_ILL}, '{1'b0, 1'b0, 1'b0, JUNK, F_IDLE},
            '{1'b0, 1'b1, 1'b0, 32'h0000_0073, F_HS}, '{1'b0, 1'b0, 1'b0, JUNK, DEC},
            '{1'b0, 1'b0, 1'b0, JUNK, H_ILL}};
      do_reset();
      foreach (v[i]) begin
         cyc(v[i].r, v[i].ifr, v[i].lsr, v[i].ins);
         n_cmp++;
         if (obs !== v[i].exp) begin n_bad++; $display("FAIL illegal[%0d]: obs=%h exp=%h", i, obs, v[i].exp); end
      end
   endtask
   task automatic test_wait;
      do_reset();
`ifdef RV_CTRL_TIMEOUT_EN
      for (int k = 1; k <= 8; k++) begin
         cyc(1'b0, 1'b0, 1'b0, JUNK);
         n_cmp++;
         if (obs !== ((k == 8) ? H_TO : F_REQ)) begin
            n_bad++;
            $display("FAIL timeout[%0d]: obs=%h exp=%h", k, obs, (k == 8) ? H_TO : F_REQ);
         end
      end
`else
      for (int k = 1; k <= 20; k++) begin
         cyc(1'b0, 1'b0, 1'b0, JUNK);
         n_cmp++;
         if (obs !== F_REQ) begin n_bad++; $display("FAIL fetch_wait[%0d]: obs=%h exp=%h", k, obs, F_REQ); end
      end
`endif
   endtask
   initial begin
      bus.ifu_ready = 1'b0;
      bus.lsu_ready = 1'b0;
      bus.inst = JUNK;
      test_reset();
      test_alu();
      test_load();
      test_rd_zero();
      test_rst_mem();
      test_back_to_back();
      test_ebreak();
      test_illegal();
      test_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
